// File: rtl/cook_program_datapath.sv
// cook_program_datapath: multi-stage cook program with BCD mm:ss countdown,
// 1 s tick prescaler, heat-level PWM and pause/resume/add-30 s controls.
module cook_program_datapath #(
    parameter  int TICKS_PER_SECOND = 50000000,
    parameter  int NUM_STAGES       = 4,
    parameter  int LEVEL_BITS       = 2,
    parameter  int PWM_TICKS        = 5000000,
    localparam int AW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int NW = ($clog2(NUM_STAGES + 1) > 1) ? $clog2(NUM_STAGES + 1) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [AW-1:0]         prog_addr,
    input  logic [15:0]           prog_duration,
    input  logic [LEVEL_BITS-1:0] prog_level,
    input  logic [NW-1:0]         num_stages,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  cancel,
    input  logic                  add30,
    output logic                  prog_err,
    output logic                  running,
    output logic                  paused,
    output logic                  done,
    output logic [AW-1:0]         stage_idx,
    output logic [15:0]           remaining,
    output logic                  sec_tick,
    output logic                  heat_pulse,
    output logic                  motor_on
);

    localparam int CW   = AW + NW + 1;
    localparam int PSW  = $clog2(TICKS_PER_SECOND);
    localparam int PCW  = (PWM_TICKS > 1) ? $clog2(PWM_TICKS) : 1;
    localparam int LMAX = (1 << LEVEL_BITS) - 1;
    localparam int MW   = PCW + LEVEL_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_COOK   = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  state_r;
    logic [2:0]              flags_r;      // {running, paused, done}
    logic [AW-1:0]           stage_idx_r;
    logic [NW-1:0]           num_run_r;
    logic [15:0]             remaining_r;
    logic                    sec_tick_r;
    logic [PSW-1:0]          presc_r;
    logic [PCW-1:0]          pwm_cnt_r;
    logic [LEVEL_BITS-1:0]   level_r;
    logic                    prog_err_r;
    logic [15:0]             dur_r [NUM_STAGES];
    logic [LEVEL_BITS-1:0]   lvl_r [NUM_STAGES];

    // Time value is legal BCD mm:ss (every digit <= 9, seconds tens <= 5).
    function automatic logic bcd_time_ok(input logic [15:0] t);
        return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
               (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

    // One-second BCD decrement; caller guarantees t is non-zero.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // BCD add of 00:30 with carry into minutes, saturating at 99:59.
    function automatic logic [15:0] bcd_add30(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[7:4] < 4'd3) begin
            r[7:4] = t[7:4] + 4'd3;
        end else begin
            r[7:4] = t[7:4] - 4'd3;
            if (t[11:8] < 4'd9) begin
                r[11:8] = t[11:8] + 4'd1;
            end else if (t[15:12] < 4'd9) begin
                r[11:8]  = 4'd0;
                r[15:12] = t[15:12] + 4'd1;
            end else begin
                r = 16'h9959;
            end
        end
        return r;
    endfunction

    // Registered status flags for each state.
    function automatic logic [2:0] state_flags(input state_t s);
        case (s)
            S_LOAD, S_COOK: return 3'b100;
            S_PAUSED:       return 3'b010;
            S_DONE:         return 3'b001;
            default:        return 3'b000;
        endcase
    endfunction

    logic        start_ok_s;
    logic        last_stage_s;
    logic        tc_s;
    logic        wr_ok_s;
    logic [15:0] dec_s;
    logic [15:0] add_s;
    logic [15:0] tick_val_s;
    logic [15:0] load_dur_s;

    assign start_ok_s   = start && (|num_stages) && (CW'(num_stages) <= CW'(NUM_STAGES));
    assign last_stage_s = (CW'(stage_idx_r) + CW'(1'b1)) == CW'(num_run_r);
    assign tc_s         = (presc_r == PSW'(TICKS_PER_SECOND - 1));
    assign wr_ok_s      = prog_we && ((state_r == S_IDLE) || (state_r == S_DONE)) &&
                          (CW'(prog_addr) < CW'(NUM_STAGES)) && bcd_time_ok(prog_duration);
    assign dec_s        = bcd_dec(remaining_r);
    assign add_s        = bcd_add30(remaining_r);
    // add30 together with a tick: +30 s then -1 s
    assign tick_val_s   = add30 ? bcd_dec(add_s) : dec_s;
    assign load_dur_s   = dur_r[stage_idx_r];

    // Program store and write-reject pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                dur_r[i] <= 16'h0000;
                lvl_r[i] <= {LEVEL_BITS{1'b0}};
            end
            prog_err_r <= 1'b0;
        end else begin
            prog_err_r <= prog_we && !wr_ok_s;
            if (wr_ok_s) begin
                dur_r[prog_addr] <= prog_duration;
                lvl_r[prog_addr] <= prog_level;
            end
        end
    end

    // Sequencer: stage walk, prescaler, BCD countdown, PWM counter and flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            flags_r     <= 3'b000;
            stage_idx_r <= {AW{1'b0}};
            num_run_r   <= {NW{1'b0}};
            remaining_r <= 16'h0000;
            sec_tick_r  <= 1'b0;
            presc_r     <= {PSW{1'b0}};
            pwm_cnt_r   <= {PCW{1'b0}};
            level_r     <= {LEVEL_BITS{1'b0}};
        end else begin
            sec_tick_r <= 1'b0;
            if (cancel) begin
                state_r     <= S_IDLE;
                flags_r     <= state_flags(S_IDLE);
                stage_idx_r <= {AW{1'b0}};
                remaining_r <= 16'h0000;
                presc_r     <= {PSW{1'b0}};
                pwm_cnt_r   <= {PCW{1'b0}};
            end else begin
                case (state_r)
                    S_IDLE, S_DONE: begin
                        if (start_ok_s) begin
                            state_r     <= S_LOAD;
                            flags_r     <= state_flags(S_LOAD);
                            stage_idx_r <= {AW{1'b0}};
                            num_run_r   <= num_stages;
                        end
                    end
                    S_LOAD: begin
                        remaining_r <= load_dur_s;
                        level_r     <= lvl_r[stage_idx_r];
                        presc_r     <= {PSW{1'b0}};
                        pwm_cnt_r   <= {PCW{1'b0}};
                        if (load_dur_s != 16'h0000) begin
                            state_r <= S_COOK;
                            flags_r <= state_flags(S_COOK);
                        end else if (last_stage_s) begin
                            state_r <= S_DONE;
                            flags_r <= state_flags(S_DONE);
                        end else begin
                            stage_idx_r <= stage_idx_r + AW'(1'b1);
                        end
                    end
                    S_COOK: begin
                        if (pause) begin
                            // counters hold; a terminal count stays pending
                            state_r <= S_PAUSED;
                            flags_r <= state_flags(S_PAUSED);
                        end else begin
                            pwm_cnt_r <= (pwm_cnt_r == PCW'(PWM_TICKS - 1)) ?
                                         {PCW{1'b0}} : pwm_cnt_r + PCW'(1'b1);
                            if (tc_s) begin
                                presc_r     <= {PSW{1'b0}};
                                remaining_r <= tick_val_s;
                                if (tick_val_s == 16'h0000) begin
                                    pwm_cnt_r <= {PCW{1'b0}};
                                    if (last_stage_s) begin
                                        state_r <= S_DONE;
                                        flags_r <= state_flags(S_DONE);
                                    end else begin
                                        stage_idx_r <= stage_idx_r + AW'(1'b1);
                                        state_r     <= S_LOAD;
                                        flags_r     <= state_flags(S_LOAD);
                                    end
                                end
                            end else begin
                                presc_r <= presc_r + PSW'(1'b1);
                                if (add30) begin
                                    remaining_r <= add_s;
                                end
                                // tick is shown during the terminal-count cycle
                                sec_tick_r <= (presc_r == PSW'(TICKS_PER_SECOND - 2));
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (add30) begin
                            remaining_r <= add_s;
                        end
                        if (start) begin
                            state_r    <= S_COOK;
                            flags_r    <= state_flags(S_COOK);
                            sec_tick_r <= tc_s;
                        end
                    end
                    default: begin
                        state_r <= S_IDLE;
                        flags_r <= state_flags(S_IDLE);
                    end
                endcase
            end
        end
    end

    assign prog_err   = prog_err_r;
    assign running    = flags_r[2];
    assign paused     = flags_r[1];
    assign done       = flags_r[0];
    assign stage_idx  = stage_idx_r;
    assign remaining  = remaining_r;
    assign sec_tick   = sec_tick_r;
    assign motor_on   = flags_r[2];
    assign heat_pulse = (state_r == S_COOK) &&
                        ((MW'(pwm_cnt_r) * MW'(LMAX)) < (MW'(level_r) * MW'(PWM_TICKS)));

endmodule

// File: tb/tb_cook_program_datapath.sv
// Self-checking bench for cook_program_datapath with a seconds-based timeline model.
module tb_cook_program_datapath;

    localparam int TPS  = 4;
    localparam int PWM  = 4;
    localparam int NS   = 4;
    localparam int LMAX = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [1:0]  prog_addr;
    logic [15:0] prog_duration;
    logic [1:0]  prog_level;
    logic [2:0]  num_stages;
    logic        start, pause, cancel, add30;
    logic        prog_err, running, paused, done;
    logic [1:0]  stage_idx;
    logic [15:0] remaining;
    logic        sec_tick, heat_pulse, motor_on;

    always #5 clock = ~clock;

    cook_program_datapath #(
        .TICKS_PER_SECOND(TPS), .NUM_STAGES(NS), .LEVEL_BITS(2), .PWM_TICKS(PWM)
    ) dut (
        .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_duration(prog_duration), .prog_level(prog_level), .num_stages(num_stages),
        .start(start), .pause(pause), .cancel(cancel), .add30(add30),
        .prog_err(prog_err), .running(running), .paused(paused), .done(done),
        .stage_idx(stage_idx), .remaining(remaining), .sec_tick(sec_tick),
        .heat_pulse(heat_pulse), .motor_on(motor_on)
    );

    typedef struct packed {
        logic        running;
        logic        paused;
        logic        done;
        logic        motor;
        logic [1:0]  stage;
        logic [15:0] rem;
        logic        tick;
        logic        heat;
    } obs_t;

    int          pass_cnt  = 0;
    int          check_cnt = 0;
    logic [15:0] mdur [NS];
    int          mlvl [NS];
    obs_t        exp_q [$];

    function automatic int sec_of(input logic [15:0] d);
        return int'(d[15:12]) * 600 + int'(d[11:8]) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic bit time_ok(input logic [15:0] d);
        return (d[15:12] < 4'd10) && (d[11:8] < 4'd10) && (d[7:4] < 4'd6) && (d[3:0] < 4'd10);
    endfunction

    function automatic obs_t mk(input bit run, input bit pau, input bit dn, input int stg,
                                input int secs, input bit tk, input bit ht);
        obs_t o;
        o.running = run; o.paused = pau; o.done = dn; o.motor = run;
        o.stage = 2'(stg); o.rem = to_bcd(secs); o.tick = tk; o.heat = ht;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.running = running; o.paused = paused; o.done = done; o.motor = motor_on;
        o.stage = stage_idx; o.rem = remaining; o.tick = sec_tick; o.heat = heat_pulse;
        return o;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected cycle-by-cycle outputs of a whole run, from the program in seconds.
    task automatic build_timeline(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            int d;
            d = sec_of(mdur[i]);
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, i, 0, 1'b0, 1'b0));
            for (int k = 0; k < d * TPS; k++) begin
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, i, d - k / TPS, (k % TPS) == TPS - 1,
                                   ((k % PWM) * LMAX) < (mlvl[i] * PWM)));
            end
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, n - 1, 0, 1'b0, 1'b0));
    endtask

    // Start a run of n stages and compare every cycle up to DONE.
    task automatic run_and_check(input int n, input string name);
        obs_t o;
        build_timeline(n);
        num_stages = 3'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        foreach (exp_q[i]) begin
            o = observe();
            check_cnt++;
            if (o !== exp_q[i])
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, o, exp_q[i]);
            else
                pass_cnt++;
            step();
        end
    endtask

    task automatic write_stage(input int addr, input logic [15:0] dur, input int lvl,
                               input bit allowed, input string name);
        bit exp_err;
        prog_we = 1'b1; prog_addr = 2'(addr); prog_duration = dur; prog_level = 2'(lvl);
        step();
        prog_we = 1'b0;
        exp_err = !(allowed && time_ok(dur));
        check_cnt++;
        if (prog_err !== exp_err)
            $display("FAIL %s prog_err: got %b expected %b", name, prog_err, exp_err);
        else
            pass_cnt++;
        if (!exp_err) begin
            mdur[addr] = dur;
            mlvl[addr] = lvl;
        end
    endtask

    task automatic go_idle(input string name);
        obs_t o;
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        o = observe();
        check_cnt++;
        if (o !== obs_t'(0)) $display("FAIL %s cancel: got %h expected 0", name, o);
        else pass_cnt++;
    endtask

    task automatic enter_cook(input int n);
        num_stages = 3'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        obs_t o;
        #12;
        o = observe();
        check_cnt++;
        if ({o, prog_err} !== 25'd0) $display("FAIL reset_state: got %h expected 0", {o, prog_err});
        else pass_cnt++;
        reset = 1'b1;
        step();
        o = observe();
        check_cnt++;
        if (o !== obs_t'(0)) $display("FAIL reset_release: got %h expected 0", o);
        else pass_cnt++;
    endtask

    task automatic test_single_stage();
        write_stage(0, 16'h0002, 3, 1'b1, "single_wr");
        run_and_check(1, "single_stage");
        go_idle("single_stage");
    endtask

    task automatic test_multi_stage();
        write_stage(0, 16'h0100, 1, 1'b1, "multi_wr0");
        write_stage(1, 16'h0000, 2, 1'b1, "multi_wr1");
        write_stage(2, 16'h0001, 0, 1'b1, "multi_wr2");
        run_and_check(3, "multi_stage");
        go_idle("multi_stage");
    endtask

    task automatic test_start_ignored();
        obs_t o;
        for (int v = 0; v < 3; v++) begin
            num_stages = (v == 0) ? 3'd0 : ((v == 1) ? 3'd5 : 3'd7);
            start = 1'b1;
            step();
            start = 1'b0;
            o = observe();
            check_cnt++;
            if (o !== obs_t'(0)) $display("FAIL start_ignored n=%0d: got %h expected 0", num_stages, o);
            else pass_cnt++;
        end
    endtask

    task automatic test_pause();
        obs_t o;
        obs_t e;
        write_stage(0, 16'h0005, 2, 1'b1, "pause_wr");
        enter_cook(1);
        step();
        step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        e = mk(1'b0, 1'b1, 1'b0, 0, 5, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            o = observe();
            check_cnt++;
            if (o !== e) $display("FAIL pause_hold cycle %0d: got %h expected %h", i, o, e);
            else pass_cnt++;
            step();
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check_cnt++;
        if (sec_tick !== 1'b0 || running !== 1'b1)
            $display("FAIL resume_1: got tick=%b running=%b expected tick=0 running=1", sec_tick, running);
        else pass_cnt++;
        step();
        check_cnt++;
        if (sec_tick !== 1'b1 || remaining !== 16'h0005)
            $display("FAIL resume_tick: got tick=%b rem=%h expected tick=1 rem=0005", sec_tick, remaining);
        else pass_cnt++;
        step();
        check_cnt++;
        if (remaining !== 16'h0004) $display("FAIL resume_dec: got %h expected 0004", remaining);
        else pass_cnt++;
        go_idle("pause");
    endtask

    task automatic test_add30();
        logic [15:0] exp_rem;
        write_stage(0, 16'h9945, 1, 1'b1, "add30_wr_sat");
        enter_cook(1);
        add30 = 1'b1;
        step();
        add30 = 1'b0;
        check_cnt++;
        if (remaining !== 16'h9959) $display("FAIL add30_saturate: got %h expected 9959", remaining);
        else pass_cnt++;
        go_idle("add30_sat");
        write_stage(0, 16'h0010, 1, 1'b1, "add30_wr_tick");
        enter_cook(1);
        step(); step(); step();
        check_cnt++;
        if (sec_tick !== 1'b1) $display("FAIL add30_tick_align: got %b expected 1", sec_tick);
        else pass_cnt++;
        add30 = 1'b1;
        step();
        add30 = 1'b0;
        check_cnt++;
        if (remaining !== 16'h0039) $display("FAIL add30_with_tick: got %h expected 0039", remaining);
        else pass_cnt++;
        go_idle("add30_tick");
        for (int r = 0; r < 6; r++) begin
            int s;
            bit in_pause;
            s = $urandom_range(1, 5999);
            in_pause = $urandom_range(0, 1) == 1;
            write_stage(0, to_bcd(s), 2, 1'b1, "add30_wr_rand");
            enter_cook(1);
            if (in_pause) begin
                pause = 1'b1;
                step();
                pause = 1'b0;
            end
            add30 = 1'b1;
            step();
            add30 = 1'b0;
            exp_rem = to_bcd((s + 30 > 5999) ? 5999 : s + 30);
            check_cnt++;
            if (remaining !== exp_rem)
                $display("FAIL add30_rand paused=%0d: got %h expected %h", in_pause, remaining, exp_rem);
            else pass_cnt++;
            go_idle("add30_rand");
        end
    endtask

    task automatic test_cancel();
        bit found;
        write_stage(0, 16'h0001, 1, 1'b1, "cancel_wr0");
        write_stage(1, 16'h0002, 2, 1'b1, "cancel_wr1");
        write_stage(2, 16'h0001, 3, 1'b1, "cancel_wr2");
        enter_cook(3);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (stage_idx == 2'd1 && remaining != 16'h0000) found = 1'b1;
            else step();
        end
        check_cnt++;
        if (!found) $display("FAIL cancel_wait: got no stage-1 COOK within bound, expected stage 1");
        else pass_cnt++;
        step();
        go_idle("cancel_stage1");
        run_and_check(3, "cancel_restart");
        go_idle("cancel_restart");
    endtask

    task automatic test_reject();
        write_stage(0, 16'h0002, 1, 1'b1, "rej_wr0");
        write_stage(1, 16'h0001, 2, 1'b1, "rej_wr1");
        write_stage(1, 16'h0060, 3, 1'b1, "rej_0060");
        check_cnt++;
        step();
        if (prog_err !== 1'b0) $display("FAIL rej_pulse: got %b expected 0", prog_err);
        else pass_cnt++;
        write_stage(0, 16'h0A00, 3, 1'b1, "rej_digitA");
        enter_cook(2);
        step();
        write_stage(1, 16'h0003, 3, 1'b0, "rej_in_cook");
        go_idle("rej_in_cook");
        run_and_check(2, "rej_retained");
        go_idle("rej_retained");
        for (int r = 0; r < 10; r++) begin
            logic [15:0] d;
            d = {($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'd0,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'd0,
                 4'($urandom_range(0, 7)), 4'($urandom_range(0, 11))};
            write_stage($urandom_range(0, NS - 1), d, $urandom_range(0, 3), 1'b1, "rand_wr");
        end
        run_and_check(4, "rand_wr_run");
        go_idle("rand_wr_run");
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 5; r++) begin
            int n;
            for (int i = 0; i < NS; i++)
                write_stage(i, to_bcd($urandom_range(0, 3)), $urandom_range(0, 3), 1'b1, "rand_run_wr");
            n = $urandom_range(1, NS);
            run_and_check(n, "rand_run");
        end
        go_idle("rand_run");
    endtask

    task automatic test_async_reset();
        obs_t o;
        write_stage(0, 16'h0005, 3, 1'b1, "areset_wr");
        enter_cook(1);
        step();
        #2;
        reset = 1'b0;
        #1;
        o = observe();
        check_cnt++;
        if ({o, prog_err} !== 25'd0) $display("FAIL async_reset: got %h expected 0", {o, prog_err});
        else pass_cnt++;
        #2;
        reset = 1'b1;
        for (int i = 0; i < NS; i++) begin
            mdur[i] = 16'h0000;
            mlvl[i] = 0;
        end
        step();
        run_and_check(4, "reset_cleared_prog");
        go_idle("reset_cleared_prog");
    endtask

    initial begin
        reset = 1'b0; prog_we = 1'b0; prog_addr = 2'd0; prog_duration = 16'h0000;
        prog_level = 2'd0; num_stages = 3'd0; start = 1'b0; pause = 1'b0;
        cancel = 1'b0; add30 = 1'b0;
        for (int i = 0; i < NS; i++) begin
            mdur[i] = 16'h0000;
            mlvl[i] = 0;
        end
        test_reset();
        test_single_stage();
        test_multi_stage();
        test_start_ignored();
        test_pause();
        test_add30();
        test_cancel();
        test_reject();
        test_random_runs();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
